// File: rtl/w0_chi_table.sv
// rtl/w0_chi_table.sv - multilinear eq (chi) table builder over w0 using one shared field multiplier
//
// field_multiplier: bit-serial modular multiplier, c = a * b mod F_Q.
//    clk, rstb     clock, asynchronous active-low reset
//    en            start request, honoured only while ready is high
//    a, b          operands (< F_Q), sampled with en
//    ready         high when idle; falls after a start, rises when c is valid
//    c             product, valid while ready is high after an operation
//
// w0_chi_table: builds chi[g] = prod_j (g_j ? w0[j] : 1 - w0[j]) mod F_Q by table doubling.
//    clk, rstb     clock, asynchronous active-low reset
//    en            rising edge starts a build (ignored unless idle)
//    w0            evaluation point, sampled on the start cycle
//    ready         table valid and block idle
//    chi           table entries 0..ngates-1

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module field_multiplier (
   input  logic                clk,
   input  logic                rstb,
   input  logic                en,
   input  logic [`F_NBITS-1:0] a,
   input  logic [`F_NBITS-1:0] b,
   output logic                ready,
   output logic [`F_NBITS-1:0] c
);

   logic                busy;
   logic [`F_NBITS-1:0] acc;
   logic [`F_NBITS-1:0] aa;
   logic [`F_NBITS-1:0] bb;

   function automatic logic [`F_NBITS-1:0] add_mod(input logic [`F_NBITS-1:0] x,
                                                   input logic [`F_NBITS-1:0] y);
      logic [`F_NBITS:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= {1'b0, `F_Q})
         s = s - {1'b0, `F_Q};
      return s[`F_NBITS-1:0];
   endfunction

   assign ready = ~busy;
   assign c     = acc;

   // LSB-first shift-and-add; latency tracks the bit length of b, so it varies per operand.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         busy <= 1'b0;
         acc  <= '0;
         aa   <= '0;
         bb   <= '0;
      end else if (!busy) begin
         if (en) begin
            busy <= 1'b1;
            acc  <= '0;
            aa   <= a;
            bb   <= b;
         end
      end else if (bb == '0) begin
         busy <= 1'b0;
      end else begin
         if (bb[0])
            acc <= add_mod(acc, aa);
         aa <= add_mod(aa, aa);
         bb <= bb >> 1;
      end
   end

endmodule

module w0_chi_table #(
   parameter  int ngates = 8,
   parameter  int ngbits = $clog2(ngates),
   localparam int wn     = (ngbits > 0) ? ngbits : 1,
   localparam int tbl_n  = 1 << wn
) (
   input  logic                clk,
   input  logic                rstb,
   input  logic                en,
   input  logic [`F_NBITS-1:0] w0 [wn],
   output logic                ready,
   output logic [`F_NBITS-1:0] chi [ngates]
);

   if (ngbits != $clog2(ngates)) begin : g_bad_ngbits
      $error("w0_chi_table: ngbits must equal $clog2(ngates)");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state;
   logic                en_dly;
   logic                start;
   logic [wn-1:0]       j_cnt;
   logic [wn-1:0]       k_cnt;
   logic [wn-1:0]       pow_j;
   logic [wn-1:0]       hi_idx;
   logic                k_last;
   logic                j_last;
   logic [`F_NBITS-1:0] tbl   [tbl_n];
   // Sized to the full counter range so j_cnt indexes it without truncation.
   logic [`F_NBITS-1:0] w_reg [tbl_n];
   logic                mult_en;
   logic [`F_NBITS-1:0] mult_a;
   logic [`F_NBITS-1:0] mult_b;
   logic                mult_ready;
   logic [`F_NBITS-1:0] mult_c;

   function automatic logic [`F_NBITS-1:0] sub_mod(input logic [`F_NBITS-1:0] x,
                                                   input logic [`F_NBITS-1:0] y);
      logic [`F_NBITS:0] d;
      if (x >= y)
         d = {1'b0, x} - {1'b0, y};
      else
         d = {1'b0, x} + {1'b0, `F_Q} - {1'b0, y};
      return d[`F_NBITS-1:0];
   endfunction

   assign start  = en & ~en_dly;
   assign pow_j  = wn'(1) << j_cnt;
   assign hi_idx = k_cnt + pow_j;
   assign k_last = (k_cnt == pow_j - wn'(1));
   assign j_last = (j_cnt == wn'(wn - 1));

   for (genvar gi = 0; gi < ngates; gi++) begin : g_chi
      assign chi[gi] = tbl[gi];
   end

   field_multiplier u_mul (
      .clk   (clk),
      .rstb  (rstb),
      .en    (mult_en),
      .a     (mult_a),
      .b     (mult_b),
      .ready (mult_ready),
      .c     (mult_c)
   );

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state   <= S_IDLE;
         ready   <= 1'b1;
         // Treat en as already high so an en held through reset cannot start a build.
         en_dly  <= 1'b1;
         mult_en <= 1'b0;
         mult_a  <= '0;
         mult_b  <= '0;
         j_cnt   <= '0;
         k_cnt   <= '0;
         for (int i = 0; i < tbl_n; i++) begin
            tbl[i]   <= '0;
            w_reg[i] <= '0;
         end
      end else begin
         en_dly  <= en;
         mult_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < tbl_n; i++) begin
                     w_reg[i] <= (i < wn) ? w0[i] : '0;
                     tbl[i]   <= (i == 0) ? `F_NBITS'(1) : '0;
                  end
                  j_cnt <= '0;
                  k_cnt <= '0;
                  ready <= 1'b0;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // A single-entry table is already complete: chi[0] = 1.
               if (ngbits == 0) begin
                  state <= S_DONE;
               end else begin
                  mult_en <= 1'b1;
                  mult_a  <= tbl[k_cnt];
                  mult_b  <= w_reg[j_cnt];
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               // mult_en is still high in the first WAIT cycle, before the multiplier has
               // dropped ready, so ready is only trusted once the pulse has gone.
               if (!mult_en && mult_ready)
                  state <= S_WRITE;
            end
            S_WRITE: begin
               // tbl[k] * (1 - w) computed as tbl[k] - tbl[k] * w, saving a multiply.
               tbl[hi_idx] <= mult_c;
               tbl[k_cnt]  <= sub_mod(tbl[k_cnt], mult_c);
               if (k_last) begin
                  k_cnt <= '0;
                  if (j_last) begin
                     j_cnt <= '0;
                     state <= S_DONE;
                  end else begin
                     j_cnt <= j_cnt + wn'(1);
                     state <= S_ISSUE;
                  end
               end else begin
                  k_cnt <= k_cnt + wn'(1);
                  state <= S_ISSUE;
               end
            end
            S_DONE: begin
               ready <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_w0_chi_table.sv
// tb/tb_w0_chi_table.sv - self-checking bench for w0_chi_table against a product-formula model
`timescale 1ns/1ps

`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

module tb_w0_chi_table;

   typedef logic [`F_NBITS-1:0] fe_t;
   localparam logic [127:0] QW = 128'(`F_Q);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstb;
   logic en8, en4, en6, en1;
   logic rdy8, rdy4, rdy6, rdy1;
   fe_t  w8 [3];
   fe_t  w4 [2];
   fe_t  w6 [3];
   fe_t  w1 [1];
   fe_t  chi8 [8];
   fe_t  chi4 [4];
   fe_t  chi6 [6];
   fe_t  chi1 [1];

   int n_tests = 0;
   int n_fail  = 0;
   int mul8_total = 0;

   w0_chi_table #(.ngates(8)) u8 (.clk(clk), .rstb(rstb), .en(en8), .w0(w8), .ready(rdy8), .chi(chi8));
   w0_chi_table #(.ngates(4)) u4 (.clk(clk), .rstb(rstb), .en(en4), .w0(w4), .ready(rdy4), .chi(chi4));
   w0_chi_table #(.ngates(6)) u6 (.clk(clk), .rstb(rstb), .en(en6), .w0(w6), .ready(rdy6), .chi(chi6));
   w0_chi_table #(.ngates(1)) u1 (.clk(clk), .rstb(rstb), .en(en1), .w0(w1), .ready(rdy1), .chi(chi1));

   always @(posedge clk) if (u8.mult_en) mul8_total++;

   // ---------------- reference model ----------------
   function automatic fe_t mulm(input fe_t a, input fe_t b);
      logic [127:0] p;
      p = 128'(a) * 128'(b);
      return fe_t'(p % QW);
   endfunction

   function automatic fe_t addm(input fe_t a, input fe_t b);
      return fe_t'((128'(a) + 128'(b)) % QW);
   endfunction

   function automatic fe_t one_minus(input fe_t a);
      return fe_t'((QW + 128'd1 - 128'(a)) % QW);
   endfunction

   function automatic fe_t chi_ref(input fe_t w [3], input int nb, input int g);
      fe_t r;
      r = 1;
      for (int j = 0; j < nb; j++)
         r = mulm(r, g[j] ? w[j] : one_minus(w[j]));
      return r;
   endfunction

   function automatic fe_t rand_fe();
      logic [63:0] r;
      int sel;
      sel = $urandom_range(0, 7);
      r = {$urandom(), $urandom()};
      case (sel)
         0: return fe_t'(0);
         1: return fe_t'(1);
         2: return fe_t'(QW - 128'd1);
         default: return fe_t'(128'(r) % QW);
      endcase
   endfunction

   function automatic logic get_rdy(input int which);
      case (which)
         0: return rdy8;
         1: return rdy4;
         2: return rdy6;
         default: return rdy1;
      endcase
   endfunction

   task automatic set_en(input int which, input logic v);
      case (which)
         0: en8 = v;
         1: en4 = v;
         2: en6 = v;
         default: en1 = v;
      endcase
   endtask

   // Pulses en for one cycle and returns how many sampled cycles ready stayed low.
   task automatic build(input int which, output int low);
      @(negedge clk); set_en(which, 1'b1);
      @(negedge clk); set_en(which, 1'b0);
      low = 0;
      while (!get_rdy(which) && low < 20000) begin
         low++;
         @(negedge clk);
      end
      n_tests++;
      if (get_rdy(which) !== 1'b1) begin
         n_fail++;
         $display("FAIL build_timeout inst=%0d ready=%b expected=1", which, get_rdy(which));
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstb = 1'b0;
      en8 = 1'b1; en4 = 1'b1; en6 = 1'b1; en1 = 1'b1;
      foreach (w8[i]) w8[i] = fe_t'(3);
      foreach (w4[i]) w4[i] = fe_t'(3);
      foreach (w6[i]) w6[i] = fe_t'(3);
      w1[0] = fe_t'(3);
      repeat (3) @(negedge clk);
      rstb = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (get_rdy(i) !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready inst=%0d got=%b expected=1", i, get_rdy(i));
         end
      end
      for (int i = 0; i < 8; i++) begin
         n_tests++;
         if (chi8[i] !== fe_t'(0)) begin
            n_fail++;
            $display("FAIL reset_chi8[%0d] got=%0h expected=0", i, chi8[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (chi4[i] !== fe_t'(0)) begin
            n_fail++;
            $display("FAIL reset_chi4[%0d] got=%0h expected=0", i, chi4[i]);
         end
      end
      n_tests++;
      if (chi1[0] !== fe_t'(0) || chi6[5] !== fe_t'(0)) begin
         n_fail++;
         $display("FAIL reset_chi1_chi6 got=%0h,%0h expected=0,0", chi1[0], chi6[5]);
      end
      en8 = 1'b0; en4 = 1'b0; en6 = 1'b0; en1 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_known4();
      fe_t exp4 [4];
      fe_t wm [3];
      int low;
      w4[0] = fe_t'(2); w4[1] = fe_t'(3);
      wm[0] = fe_t'(2); wm[1] = fe_t'(3); wm[2] = fe_t'(0);
      exp4[0] = fe_t'(2);
      exp4[1] = fe_t'(QW - 128'd4);
      exp4[2] = fe_t'(QW - 128'd3);
      exp4[3] = fe_t'(6);
      build(1, low);
      n_tests++;
      if (low == 0) begin
         n_fail++;
         $display("FAIL known4_ready_fell low_cycles=%0d expected>0", low);
      end
      for (int g = 0; g < 4; g++) begin
         n_tests++;
         if (chi4[g] !== exp4[g] || chi4[g] !== chi_ref(wm, 2, g)) begin
            n_fail++;
            $display("FAIL known4_chi[%0d] got=%0h expected=%0h", g, chi4[g], exp4[g]);
         end
      end
   endtask

   task automatic test_onehot8();
      int low;
      int m0;
      w8[0] = fe_t'(1); w8[1] = fe_t'(0); w8[2] = fe_t'(1);
      m0 = mul8_total;
      build(0, low);
      n_tests++;
      if (mul8_total - m0 != 7) begin
         n_fail++;
         $display("FAIL onehot8_mult_count got=%0d expected=7", mul8_total - m0);
      end
      for (int g = 0; g < 8; g++) begin
         n_tests++;
         if (chi8[g] !== ((g == 5) ? fe_t'(1) : fe_t'(0))) begin
            n_fail++;
            $display("FAIL onehot8_chi[%0d] got=%0h expected=%0d", g, chi8[g], (g == 5));
         end
      end
      w8[0] = fe_t'(0); w8[1] = fe_t'(0); w8[2] = fe_t'(0);
      build(0, low);
      for (int g = 0; g < 8; g++) begin
         n_tests++;
         if (chi8[g] !== ((g == 0) ? fe_t'(1) : fe_t'(0))) begin
            n_fail++;
            $display("FAIL zero8_chi[%0d] got=%0h expected=%0d", g, chi8[g], (g == 0));
         end
      end
   endtask

   task automatic test_random();
      fe_t wm [3];
      fe_t s;
      int low;
      for (int it = 0; it < 4; it++) begin
         foreach (w6[i]) begin w6[i] = rand_fe(); wm[i] = w6[i]; end
         build(2, low);
         for (int g = 0; g < 6; g++) begin
            n_tests++;
            if (chi6[g] !== chi_ref(wm, 3, g)) begin
               n_fail++;
               $display("FAIL rand6_chi[%0d] it=%0d got=%0h expected=%0h", g, it, chi6[g], chi_ref(wm, 3, g));
            end
         end
         s = 0;
         for (int i = 0; i < 8; i++) s = addm(s, u6.tbl[i]);
         n_tests++;
         if (s !== fe_t'(1)) begin
            n_fail++;
            $display("FAIL rand6_table_sum it=%0d got=%0h expected=1", it, s);
         end
         foreach (w8[i]) begin w8[i] = rand_fe(); wm[i] = w8[i]; end
         build(0, low);
         for (int g = 0; g < 8; g++) begin
            n_tests++;
            if (chi8[g] !== chi_ref(wm, 3, g)) begin
               n_fail++;
               $display("FAIL rand8_chi[%0d] it=%0d got=%0h expected=%0h", g, it, chi8[g], chi_ref(wm, 3, g));
            end
         end
      end
   endtask

   task automatic test_mid_edge();
      fe_t wm [3];
      int cnt;
      int lows;
      foreach (w8[i]) begin w8[i] = rand_fe(); wm[i] = w8[i]; end
      @(negedge clk); en8 = 1'b1;
      @(negedge clk); en8 = 1'b0;
      repeat (30) @(negedge clk);
      n_tests++;
      if (rdy8 !== 1'b0) begin
         n_fail++;
         $display("FAIL midedge_busy ready=%b expected=0", rdy8);
      end
      foreach (w8[i]) w8[i] = rand_fe();
      en8 = 1'b1;
      @(negedge clk); en8 = 1'b0;
      cnt = 0;
      while (!rdy8 && cnt < 20000) begin cnt++; @(negedge clk); end
      n_tests++;
      if (rdy8 !== 1'b1) begin
         n_fail++;
         $display("FAIL midedge_timeout ready=%b expected=1", rdy8);
      end
      for (int g = 0; g < 8; g++) begin
         n_tests++;
         if (chi8[g] !== chi_ref(wm, 3, g)) begin
            n_fail++;
            $display("FAIL midedge_chi[%0d] got=%0h expected=%0h", g, chi8[g], chi_ref(wm, 3, g));
         end
      end
      lows = 0;
      repeat (10) begin @(negedge clk); if (!rdy8) lows++; end
      n_tests++;
      if (lows != 0) begin
         n_fail++;
         $display("FAIL midedge_no_queue low_cycles=%0d expected=0", lows);
      end
   endtask

   task automatic test_ngates1();
      int low;
      w1[0] = rand_fe();
      build(3, low);
      n_tests++;
      if (low != 2) begin
         n_fail++;
         $display("FAIL ngates1_ready_low got=%0d expected=2", low);
      end
      n_tests++;
      if (chi1[0] !== fe_t'(1)) begin
         n_fail++;
         $display("FAIL ngates1_chi0 got=%0h expected=1", chi1[0]);
      end
   endtask

   task automatic test_reset_mid();
      fe_t wm [3];
      int cnt;
      int low;
      foreach (w8[i]) w8[i] = rand_fe();
      @(negedge clk); en8 = 1'b1;
      @(negedge clk); en8 = 1'b0;
      cnt = 0;
      while (!(u8.j_cnt == 1 && u8.k_cnt == 0) && cnt < 20000) begin cnt++; @(negedge clk); end
      n_tests++;
      if (!(u8.j_cnt == 1 && u8.k_cnt == 0)) begin
         n_fail++;
         $display("FAIL rstmid_reach_j1k0 waited=%0d expected j=1 k=0", cnt);
      end
      #1 rstb = 1'b0;
      #1;
      n_tests++;
      if (rdy8 !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready got=%b expected=1", rdy8);
      end
      for (int g = 0; g < 8; g++) begin
         n_tests++;
         if (chi8[g] !== fe_t'(0)) begin
            n_fail++;
            $display("FAIL rstmid_chi[%0d] got=%0h expected=0", g, chi8[g]);
         end
      end
      @(negedge clk); rstb = 1'b1;
      @(negedge clk);
      foreach (w8[i]) begin w8[i] = rand_fe(); wm[i] = w8[i]; end
      build(0, low);
      for (int g = 0; g < 8; g++) begin
         n_tests++;
         if (chi8[g] !== chi_ref(wm, 3, g)) begin
            n_fail++;
            $display("FAIL rstmid_fresh_chi[%0d] got=%0h expected=%0h", g, chi8[g], chi_ref(wm, 3, g));
         end
      end
   endtask

   initial begin
      test_reset();
      test_known4();
      test_onehot8();
      test_random();
      test_mid_edge();
      test_ngates1();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
